ss_adc_counter_array: RTL

Parametrised single-slope ADC back-end: drives the ramp reset and ramp code for the on-chip ramp, then time-stamps the first rising edge of every column comparator with the current ramp code. Each finished frame is latched into a double buffer and streamed out over a valid/ready readout port in OUT_W-bit words. It sits between the analog comparator array and the frame readout/packetiser logic.

---
 rtl/ss_adc_counter_array.sv | 101 ++++++++++
 1 files changed

// File: rtl/ss_adc_counter_array.sv
// ss_adc_counter_array: single-slope ADC ramp control, per-channel first-edge time-stamping and double-buffered frame readout
module ss_adc_counter_array #(
    parameter int N_CH   = 128,
    parameter int RES    = 8,
    parameter int SETTLE = 7,
    parameter int OUT_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [N_CH-1:0]   cmp_in,
    output logic              ramp_reset,
    output logic [RES-1:0]    ramp_count,
    output logic              frame_done,
    output logic              overrun,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [OUT_W-1:0]  rd_data,
    output logic              rd_last
);
    localparam int NW = N_CH * RES / OUT_W;
    localparam int SW = SETTLE > 1 ? $clog2(SETTLE) : 1;
    localparam int IW = NW > 1 ? $clog2(NW) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_RAMP, S_LATCH} state_t;
    state_t state, state_nx;

    logic [SW-1:0]       settle_cnt;
    logic [N_CH-1:0]     prev, captured;
    logic [N_CH*RES-1:0] result, frame_buf;
    logic [IW-1:0]       rd_idx;
    logic                ramp_end, rd_fire, load;

    assign ramp_end   = state == S_RAMP && ramp_count == '1;
    assign ramp_reset = state != S_RAMP;
    assign frame_done = state == S_LATCH;
    assign rd_data    = frame_buf[OUT_W-1:0];
    assign rd_last    = rd_valid && rd_idx == IW'(NW - 1);
    assign rd_fire    = rd_valid && rd_ready;
    // a frame may replace the buffer on the same edge its last word leaves
    assign load       = state == S_LATCH && (!rd_valid || (rd_fire && rd_last));

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   state_nx = enable ? S_SETTLE : S_IDLE;
            S_SETTLE: state_nx = !enable ? S_IDLE : settle_cnt == SW'(SETTLE - 1) ? S_RAMP : S_SETTLE;
            S_RAMP:   state_nx = !enable ? S_IDLE : ramp_end ? S_LATCH : S_RAMP;
            default:  state_nx = enable ? S_SETTLE : S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            settle_cnt <= '0;
            ramp_count <= '0;
            prev       <= '0;
            captured   <= '0;
            result     <= '0;
            overrun    <= 1'b0;
            rd_valid   <= 1'b0;
            rd_idx     <= '0;
            frame_buf  <= '0;
        end else begin
            settle_cnt <= state == S_SETTLE ? settle_cnt + 1'b1 : '0;
            ramp_count <= (state == S_RAMP && state_nx == S_RAMP) ? ramp_count + 1'b1 : '0;
            if (state == S_SETTLE) begin
                prev     <= '0;
                captured <= '0;
                result   <= '0;
            end else if (state == S_RAMP) begin
                prev <= cmp_in;
                for (int i = 0; i < N_CH; i++) begin
                    if (cmp_in[i] && !prev[i] && !captured[i]) begin
                        result[i*RES +: RES] <= ramp_count;
                        captured[i]          <= 1'b1;
                    end else if (ramp_end && !captured[i]) begin
                        result[i*RES +: RES] <= '1;
                    end
                end
            end
            if (load) begin
                frame_buf <= result;
                rd_valid  <= 1'b1;
                rd_idx    <= '0;
            end else begin
                if (state == S_LATCH) overrun <= 1'b1;
                if (rd_fire) begin
                    frame_buf <= frame_buf >> OUT_W;
                    rd_idx    <= rd_idx + 1'b1;
                    if (rd_last) rd_valid <= 1'b0;
                end
            end
        end
    end
endmodule
